// File: rtl/cache_if.sv
// MEM-stage request/response and SRAM-controller handshake grouped for the data cache.
// master: pipeline/SRAM side that drives requests and SRAM responses; slave: the cache.
interface cache_if;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        sram_rd_en;
    logic        sram_wr_en;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [63:0] sram_rdata;
    logic        sram_ready;

    modport master (
        output rd_en, wr_en, addr, wdata, sram_rdata, sram_ready,
        input  rdata, ready, sram_rd_en, sram_wr_en, sram_addr, sram_wdata
    );

    modport slave (
        input  rd_en, wr_en, addr, wdata, sram_rdata, sram_ready,
        output rdata, ready, sram_rd_en, sram_wr_en, sram_addr, sram_wdata
    );
endinterface

// File: rtl/cache_controller.sv
// Two-way set-associative write-through data cache between MEM stage and SRAM controller.
// Optional macro CACHE_WRITE_UPDATE_EN: write hits update the cached word instead of invalidating it.
module cache_controller #(
    parameter logic [31:0] BASE_ADDR = 32'd1024,
    parameter int          SETS      = 64,
    parameter int          TAG_W     = 10
) (
    input logic   clk,
    input logic   rst,
    cache_if.slave bus
);
    localparam int IDX_W   = $clog2(SETS);
    localparam int TAG_LSB = 3 + IDX_W;

    typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_t;
    state_t state, state_nxt;

    logic [31:0]      ea;
    logic             word_sel;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             unused_ea;

    assign ea        = bus.addr - BASE_ADDR;
    assign word_sel  = ea[2];
    assign idx       = ea[3 +: IDX_W];
    assign tag       = ea[TAG_LSB +: TAG_W];
    assign unused_ea = ^{ea[31:TAG_LSB+TAG_W], ea[1:0]};

    logic [SETS-1:0]  valid_q [2];
    logic [SETS-1:0]  lru_q;
    logic [TAG_W-1:0] tag_q   [2][SETS];
    logic [63:0]      data_q  [2][SETS];

    logic [1:0]  hit;
    logic        hit_any, hit_way, victim;
    logic [31:0] hit_word;
    logic        rd_hit, fill, wr_done;

    always_comb begin
        hit = '0;
        for (int w = 0; w < 2; w++)
            hit[w] = valid_q[w][idx] && (tag_q[w][idx] == tag);
    end

    // way 0 wins a double match; a fill prefers an empty way before evicting the LRU one
    assign hit_any  = |hit;
    assign hit_way  = ~hit[0];
    assign victim   = ~valid_q[0][idx] ? 1'b0 : (~valid_q[1][idx] ? 1'b1 : lru_q[idx]);
    assign hit_word = word_sel ? data_q[hit_way][idx][63:32] : data_q[hit_way][idx][31:0];

    assign rd_hit  = (state == IDLE) && !bus.wr_en && bus.rd_en && hit_any;
    assign fill    = (state == RD_MISS) && bus.sram_ready;
    assign wr_done = (state == WR_THRU) && bus.sram_ready;

    assign bus.sram_addr  = bus.addr;
    assign bus.sram_wdata = bus.wdata;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        bus.ready      = 1'b0;
        bus.rdata      = '0;
        bus.sram_rd_en = 1'b0;
        bus.sram_wr_en = 1'b0;
        case (state)
            IDLE: begin
                if (bus.wr_en) begin
                    state_nxt = WR_THRU;
                end else if (bus.rd_en) begin
                    if (hit_any) begin
                        bus.ready = 1'b1;
                        bus.rdata = hit_word;
                    end else begin
                        state_nxt = RD_MISS;
                    end
                end else begin
                    bus.ready = 1'b1;
                end
            end
            RD_MISS: begin
                bus.sram_rd_en = 1'b1;
                if (bus.sram_ready) begin
                    bus.ready = 1'b1;
                    bus.rdata = word_sel ? bus.sram_rdata[63:32] : bus.sram_rdata[31:0];
                    state_nxt = IDLE;
                end
            end
            WR_THRU: begin
                bus.sram_wr_en = 1'b1;
                if (bus.sram_ready) begin
                    bus.ready = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q[0] <= '0;
            valid_q[1] <= '0;
            lru_q      <= '0;
        end else if (fill) begin
            valid_q[victim][idx] <= 1'b1;
            lru_q[idx]           <= ~victim;
        end else if (rd_hit) begin
            lru_q[idx] <= ~hit_way;
        end else if (wr_done && hit_any) begin
`ifdef CACHE_WRITE_UPDATE_EN
            lru_q[idx] <= ~hit_way;
`else
            valid_q[hit_way][idx] <= 1'b0;
`endif
        end
    end

    // payload arrays carry no reset; the valid bits alone decide what is live
    always_ff @(posedge clk) begin
        if (!rst && fill) begin
            tag_q[victim][idx]  <= tag;
            data_q[victim][idx] <= bus.sram_rdata;
        end
`ifdef CACHE_WRITE_UPDATE_EN
        else if (!rst && wr_done && hit_any) begin
            if (word_sel) data_q[hit_way][idx][63:32] <= bus.wdata;
            else          data_q[hit_way][idx][31:0]  <= bus.wdata;
        end
`endif
    end
endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: a per-set MRU-ordered line list predicts every cycle's outputs.
module tb_cache_controller;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_if bus();

    cache_controller #(.BASE_ADDR(32'd1024), .SETS(64), .TAG_W(10)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // expected outputs for the current cycle
    logic        chk_en = 1'b0;
    logic        e_ready, e_srd, e_swr, e_rd_mask;
    logic [31:0] e_rdata;
    logic        s_ready;
    logic [31:0] s_rdata;

    // literal checks handed to the compare process
    int          lit_seq = 0;
    int          lit_seen = 0;
    string       lit_name;
    logic [31:0] lit_act, lit_exp;

    // model: each set holds up to two lines, slot 0 most recently used
    int          m_cnt [64];
    logic [9:0]  m_tag [64][2];
    logic [63:0] m_blk [64][2];

    function automatic logic [31:0] ea_of(input logic [31:0] a);
        return a - 32'd1024;
    endfunction

    function automatic int find(input logic [5:0] s, input logic [9:0] t);
        for (int i = 0; i < m_cnt[s]; i++)
            if (m_tag[s][i] == t) return i;
        return -1;
    endfunction

    task automatic touch(input logic [5:0] s, input int p);
        logic [9:0]  t;
        logic [63:0] b;
        if (p == 1) begin
            t = m_tag[s][0]; b = m_blk[s][0];
            m_tag[s][0] = m_tag[s][1]; m_blk[s][0] = m_blk[s][1];
            m_tag[s][1] = t; m_blk[s][1] = b;
        end
    endtask

    task automatic m_fill(input logic [5:0] s, input logic [9:0] t, input logic [63:0] b);
        m_tag[s][1] = m_tag[s][0]; m_blk[s][1] = m_blk[s][0];
        m_tag[s][0] = t; m_blk[s][0] = b;
        if (m_cnt[s] < 2) m_cnt[s]++;
    endtask

    task automatic m_reset();
        for (int i = 0; i < 64; i++) m_cnt[i] = 0;
    endtask

    // compare process
    initial begin
        forever begin
            @(negedge clk);
            if (lit_seq != lit_seen) begin
                lit_seen = lit_seq;
                vectors++;
                if (lit_act !== lit_exp) begin
                    miscompares++;
                    $display("FAIL %s: got %0h, expected %0h", lit_name, lit_act, lit_exp);
                end
            end
            if (chk_en) begin
                vectors++;
                if (bus.ready !== e_ready || (!e_rd_mask && bus.rdata !== e_rdata) ||
                    bus.sram_rd_en !== e_srd || bus.sram_wr_en !== e_swr ||
                    bus.sram_addr !== bus.addr || bus.sram_wdata !== bus.wdata) begin
                    miscompares++;
                    $display("FAIL cycle@%0t: ready %b/%b rdata %h/%h sram_rd_en %b/%b sram_wr_en %b/%b sram_addr %h/%h sram_wdata %h/%h (got/expected)",
                             $time, bus.ready, e_ready, bus.rdata, e_rdata, bus.sram_rd_en, e_srd,
                             bus.sram_wr_en, e_swr, bus.sram_addr, bus.addr, bus.sram_wdata, bus.wdata);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish, vectors %0d", vectors);
        $fatal(1);
    end

    task automatic cyc(input logic r, input logic [31:0] d, input logic srd, input logic swr);
        e_ready = r; e_rdata = d; e_srd = srd; e_swr = swr; chk_en = 1'b1;
        @(negedge clk);
        s_ready = bus.ready;
        s_rdata = bus.rdata;
        @(posedge clk); #1;
    endtask

    task automatic lit(input string n, input logic [31:0] act, input logic [31:0] exp);
        chk_en = 1'b0;
        lit_name = n; lit_act = act; lit_exp = exp;
        lit_seq++;
        @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic idle(input logic srdy);
        bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.sram_ready = srdy;
        cyc(1'b1, 32'h0, 1'b0, 1'b0);
        bus.sram_ready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input int lat, input logic [63:0] blk,
                           output logic hit_o, output int low, output logic [31:0] data);
        logic [31:0] ea;
        int p;
        ea = ea_of(a);
        p = find(ea[8:3], ea[18:9]);
        low = 0;
        e_rd_mask = 1'b0;
        bus.rd_en = 1'b1; bus.wr_en = 1'b0; bus.addr = a;
        if (p >= 0) begin
            hit_o = 1'b1;
            cyc(1'b1, ea[2] ? m_blk[ea[8:3]][p][63:32] : m_blk[ea[8:3]][p][31:0], 1'b0, 1'b0);
            touch(ea[8:3], p);
        end else begin
            hit_o = 1'b0;
            cyc(1'b0, 32'h0, 1'b0, 1'b0);
            if (!s_ready) low++;
            for (int i = 0; i < lat; i++) begin
                cyc(1'b0, 32'h0, 1'b1, 1'b0);
                if (!s_ready) low++;
            end
            bus.sram_ready = 1'b1; bus.sram_rdata = blk;
            cyc(1'b1, ea[2] ? blk[63:32] : blk[31:0], 1'b1, 1'b0);
            bus.sram_ready = 1'b0;
            m_fill(ea[8:3], ea[18:9], blk);
        end
        data = s_rdata;
        bus.rd_en = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int lat, input logic also_rd);
        logic [31:0] ea;
        int p;
        ea = ea_of(a);
        e_rd_mask = also_rd;
        bus.wr_en = 1'b1; bus.rd_en = also_rd; bus.addr = a; bus.wdata = d;
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < lat; i++) cyc(1'b0, 32'h0, 1'b0, 1'b1);
        bus.sram_ready = 1'b1;
        cyc(1'b1, 32'h0, 1'b0, 1'b1);
        bus.sram_ready = 1'b0;
        p = find(ea[8:3], ea[18:9]);
        if (p >= 0) begin
`ifdef CACHE_WRITE_UPDATE_EN
            if (ea[2]) m_blk[ea[8:3]][p][63:32] = d;
            else       m_blk[ea[8:3]][p][31:0]  = d;
            touch(ea[8:3], p);
`else
            if (p == 0) begin
                m_tag[ea[8:3]][0] = m_tag[ea[8:3]][1];
                m_blk[ea[8:3]][0] = m_blk[ea[8:3]][1];
            end
            m_cnt[ea[8:3]]--;
`endif
        end
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        e_rd_mask = 1'b0;
    endtask

    function automatic logic [63:0] mk(input logic [31:0] a);
        return {a ^ 32'h5A5A_0000, ~a};
    endfunction

    logic        h;
    int          low;
    logic [31:0] d;

    initial begin
        bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.addr = 32'd1024; bus.wdata = 32'h0;
        bus.sram_rdata = 64'h0; bus.sram_ready = 1'b0;
        e_rd_mask = 1'b0;
        m_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cyc(1'b1, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        idle(1'b1);
        idle(1'b0);

        // cold miss then hits on both words of the block
        do_read(32'd1024, 3, 64'h0000_0002_0000_0001, h, low, d);
        lit("miss_freeze_cycles", low, 32'd4);
        lit("miss_rdata", d, 32'h1);
        do_read(32'd1024, 0, 64'h0, h, low, d);
        lit("rehit_1024", {31'h0, h}, 32'h1);
        do_read(32'd1028, 0, 64'h0, h, low, d);
        lit("hit_1028_rdata", d, 32'h2);

        // three tags in set 0
        do_read(32'd1536, 1, mk(32'd1536), h, low, d);
        do_read(32'd2048, 0, mk(32'd2048), h, low, d);
        lit("miss_lat0_freeze", low, 32'd1);
        do_read(32'd1536, 0, 64'h0, h, low, d);
        lit("hit_1536", {31'h0, h}, 32'h1);
        do_read(32'd1024, 2, 64'h0000_0002_0000_0001, h, low, d);
        lit("evicted_1024", {31'h0, h}, 32'h0);

        // LRU updated by a hit in set 5
        do_read(32'd1064, 1, mk(32'd1064), h, low, d);
        do_read(32'd1576, 1, mk(32'd1576), h, low, d);
        do_read(32'd1064, 0, 64'h0, h, low, d);
        do_read(32'd2088, 2, mk(32'd2088), h, low, d);
        do_read(32'd1064, 0, 64'h0, h, low, d);
        lit("lru_keep_A", {31'h0, h}, 32'h1);
        do_read(32'd1580, 1, mk(32'd1576), h, low, d);
        lit("lru_evict_B", {31'h0, h}, 32'h0);

        // store hit on a cached line
        do_write(32'd1024, 32'hDEAD_BEEF, 2, 1'b0);
        do_read(32'd1024, 1, mk(32'd1024), h, low, d);
`ifdef CACHE_WRITE_UPDATE_EN
        lit("store_update_hit", {31'h0, h}, 32'h1);
        lit("store_update_data", d, 32'hDEAD_BEEF);
`else
        lit("store_invalidate", {31'h0, h}, 32'h0);
`endif

        // store miss, with a simultaneous load request that the store overrides
        do_write(32'd2048, 32'h1234_5678, 1, 1'b1);
        do_read(32'd2048, 0, mk(32'd2048), h, low, d);
        lit("store_no_alloc", {31'h0, h}, 32'h0);
        do_write(32'd2052, 32'hCAFE_F00D, 0, 1'b0);

        // reset during a fill
        bus.rd_en = 1'b1; bus.addr = 32'd3000;
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        rst = 1'b1; bus.rd_en = 1'b0;
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        rst = 1'b0;
        m_reset();
        idle(1'b1);
        do_read(32'd3000, 1, mk(32'd3000), h, low, d);
        lit("rst_refetch", {31'h0, h}, 32'h0);
        do_read(32'd1064, 0, mk(32'd1064), h, low, d);
        lit("rst_invalidate", {31'h0, h}, 32'h0);
        do_read(32'd3004, 0, 64'h0, h, low, d);
        lit("post_rst_hit_word1", d, 32'd3000 ^ 32'h5A5A_0000);
        idle(1'b0);

        chk_en = 1'b0;
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
